// File: rtl/coe_sram_arbiter.sv
// Shares the single-port coefficient SRAM between the measurement lookup path
// (high-priority reads) and the coefficient loader (low-priority reads/writes).
module coe_sram_arbiter #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned RD_LAT    = 2,
    parameter int unsigned WR_STARVE = 8
) (
    input  logic              i_clk_50m,
    input  logic              i_rst,
    input  logic              i_meas_rd_req,
    input  logic [ADDR_W-1:0] i_meas_rd_addr,
    output logic              o_meas_rd_ack,
    output logic              o_meas_rd_valid,
    output logic [DATA_W-1:0] o_meas_rd_data,
    input  logic              i_load_req,
    input  logic              i_load_we,
    input  logic [ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0] i_load_wdata,
    output logic              o_load_ack,
    output logic              o_load_rd_valid,
    output logic [DATA_W-1:0] o_load_rd_data,
    output logic              o_sram_ce,
    output logic              o_sram_we,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_wdata,
    input  logic [DATA_W-1:0] i_sram_rdata,
    input  logic              i_stat_clr,
    output logic [15:0]       o_stall_cnt,
    output logic              o_busy
);

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STALL_W = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_starve_cnt;
    logic [RD_LAT:0]    r_tag_vld;
    logic [RD_LAT:0]    r_tag_own;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_sram_ce;
    logic               r_sram_we;
    logic [ADDR_W-1:0]  r_sram_addr;
    logic [DATA_W-1:0]  r_sram_wdata;
    logic               r_meas_rd_valid;
    logic [DATA_W-1:0]  r_meas_rd_data;
    logic               r_load_rd_valid;
    logic [DATA_W-1:0]  r_load_rd_data;

    logic w_lock;
    logic w_pipe_empty;
    logic w_meas_xfer;
    logic w_load_rd_ok;
    logic w_load_wr_ok;
    logic w_load_ack;
    logic w_load_xfer;
    logic w_load_wr_xfer;
    logic w_load_rd_xfer;
    logic w_rd_issue;
    logic w_tag_next_any;

    // READ/DRAIN are entered exactly when the tag pipeline will hold a read
    assign w_lock       = (r_starve_cnt == CNT_W'(WR_STARVE));
    assign w_pipe_empty = (r_state == S_IDLE) || (r_state == S_WRITE);

    assign w_meas_xfer    = i_meas_rd_req && !w_lock;
    assign w_load_rd_ok   = !i_meas_rd_req || w_lock;
    assign w_load_wr_ok   = w_pipe_empty && !w_meas_xfer;
    assign w_load_ack     = i_load_we ? w_load_wr_ok : w_load_rd_ok;
    assign w_load_xfer    = i_load_req && w_load_ack;
    assign w_load_wr_xfer = w_load_xfer && i_load_we;
    assign w_load_rd_xfer = w_load_xfer && !i_load_we;
    assign w_rd_issue     = w_meas_xfer || w_load_rd_xfer;
    assign w_tag_next_any = w_rd_issue || (|r_tag_vld[RD_LAT-1:0]);

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        if (w_load_wr_xfer) begin
            w_state_nxt = S_WRITE;
        end else if (w_tag_next_any) begin
            w_state_nxt = (w_lock || (i_load_req && i_load_we)) ? S_DRAIN : S_READ;
        end
    end

    // Starvation counter: measurement grants seen while the loader waits
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_starve_cnt <= '0;
        end else if (w_load_xfer || !i_load_req) begin
            r_starve_cnt <= '0;
        end else if (w_meas_xfer) begin
            r_starve_cnt <= r_starve_cnt + CNT_W'(1);
        end
    end

    // Tag pipeline: stage 0 aligns with o_sram_ce, stage RD_LAT with returned data
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_tag_vld <= '0;
            r_tag_own <= '0;
        end else begin
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_rd_issue};
            r_tag_own <= {r_tag_own[RD_LAT-1:0], w_load_rd_xfer};
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_sram_ce    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;
        end else begin
            r_sram_ce <= w_meas_xfer || w_load_xfer;
            r_sram_we <= w_load_wr_xfer;
            if (w_meas_xfer) begin
                r_sram_addr <= i_meas_rd_addr;
            end else if (w_load_xfer) begin
                r_sram_addr <= i_load_addr;
            end
            if (w_load_wr_xfer) begin
                r_sram_wdata <= i_load_wdata;
            end
        end
    end

    // Route returned data to the tagged owner; data holds until its next return
    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_meas_rd_valid <= 1'b0;
            r_meas_rd_data  <= '0;
            r_load_rd_valid <= 1'b0;
            r_load_rd_data  <= '0;
        end else begin
            r_meas_rd_valid <= r_tag_vld[RD_LAT] && !r_tag_own[RD_LAT];
            r_load_rd_valid <= r_tag_vld[RD_LAT] && r_tag_own[RD_LAT];
            if (r_tag_vld[RD_LAT] && !r_tag_own[RD_LAT]) begin
                r_meas_rd_data <= i_sram_rdata;
            end
            if (r_tag_vld[RD_LAT] && r_tag_own[RD_LAT]) begin
                r_load_rd_data <= i_sram_rdata;
            end
        end
    end

    always_ff @(posedge i_clk_50m) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
        end else if (i_stat_clr) begin
            r_stall_cnt <= '0;
        end else if (i_meas_rd_req && w_lock && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_W'(1);
        end
    end

    assign o_meas_rd_ack   = !w_lock;
    assign o_load_ack      = w_load_ack;
    assign o_meas_rd_valid = r_meas_rd_valid;
    assign o_meas_rd_data  = r_meas_rd_data;
    assign o_load_rd_valid = r_load_rd_valid;
    assign o_load_rd_data  = r_load_rd_data;
    assign o_sram_ce       = r_sram_ce;
    assign o_sram_we       = r_sram_we;
    assign o_sram_addr     = r_sram_addr;
    assign o_sram_wdata    = r_sram_wdata;
    assign o_stall_cnt     = r_stall_cnt;
    assign o_busy          = r_sram_ce || (r_state == S_READ) || (r_state == S_DRAIN);

endmodule

// File: tb/tb_coe_sram_arbiter.sv
// Directed bench for coe_sram_arbiter with an SRAM model and a per-owner
// scoreboard of expected read returns (data and arrival cycle).
module tb_coe_sram_arbiter;

    localparam int unsigned ADDR_W    = 18;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned RD_LAT    = 2;
    localparam int unsigned WR_STARVE = 8;

    logic              clk;
    logic              rst;
    logic              meas_req;
    logic [ADDR_W-1:0] meas_addr;
    logic              meas_ack;
    logic              meas_valid;
    logic [DATA_W-1:0] meas_data;
    logic              load_req;
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [DATA_W-1:0] load_wdata;
    logic              load_ack;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              sram_ce;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;
    logic              stat_clr;
    logic [15:0]       stall_cnt;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t q_meas[$];
    exp_t q_load[$];

    logic [DATA_W-1:0] ref_mem  [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sram_mem [logic [ADDR_W-1:0]];
    logic [DATA_W-1:0] sram_pipe [RD_LAT];

    coe_sram_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .RD_LAT   (RD_LAT),
        .WR_STARVE(WR_STARVE)
    ) dut (
        .i_clk_50m      (clk),
        .i_rst          (rst),
        .i_meas_rd_req  (meas_req),
        .i_meas_rd_addr (meas_addr),
        .o_meas_rd_ack  (meas_ack),
        .o_meas_rd_valid(meas_valid),
        .o_meas_rd_data (meas_data),
        .i_load_req     (load_req),
        .i_load_we      (load_we),
        .i_load_addr    (load_addr),
        .i_load_wdata   (load_wdata),
        .o_load_ack     (load_ack),
        .o_load_rd_valid(load_valid),
        .o_load_rd_data (load_data),
        .o_sram_ce      (sram_ce),
        .o_sram_we      (sram_we),
        .o_sram_addr    (sram_addr),
        .o_sram_wdata   (sram_wdata),
        .i_sram_rdata   (sram_rdata),
        .i_stat_clr     (stat_clr),
        .o_stall_cnt    (stall_cnt),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ 16'hC3A5;
    endfunction

    function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    function automatic logic [DATA_W-1:0] sram_rd(input logic [ADDR_W-1:0] a);
        if (sram_mem.exists(a)) return sram_mem[a];
        return pat(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM model: read data appears RD_LAT cycles after the strobe
    assign sram_rdata = sram_pipe[RD_LAT-1];
    initial begin
        forever begin
            @(posedge clk);
            if (sram_ce && sram_we) sram_mem[sram_addr] = sram_wdata;
            sram_pipe[0] <= (sram_ce && !sram_we) ? sram_rd(sram_addr) : 16'hDEAD;
            for (int i = 1; i < int'(RD_LAT); i++) sram_pipe[i] <= sram_pipe[i-1];
        end
    end

    // Transfer monitor: push expected returns at each accepted request
    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) begin
                q_meas.delete();
                q_load.delete();
            end else begin
                if (meas_req && meas_ack)
                    q_meas.push_back('{data: ref_rd(meas_addr), due: edge_n + int'(RD_LAT) + 1});
                if (load_req && load_ack) begin
                    if (load_we) ref_mem[load_addr] = load_wdata;
                    else q_load.push_back('{data: ref_rd(load_addr), due: edge_n + int'(RD_LAT) + 1});
                end
            end
        end
    end

    // Return checker: each valid pulse must match the queue head in cycle and data
    initial begin
        logic ev_m;
        logic ev_l;
        forever begin
            @(negedge clk);
            ev_m = (q_meas.size() > 0) && (q_meas[0].due == edge_n);
            ev_l = (q_load.size() > 0) && (q_load[0].due == edge_n);
            if (meas_valid || ev_m) begin
                check("meas_rd_valid", 32'(meas_valid), 32'(ev_m));
                if (ev_m) begin
                    check("meas_rd_data", 32'(meas_data), 32'(q_meas[0].data));
                    void'(q_meas.pop_front());
                end
            end
            if (load_valid || ev_l) begin
                check("load_rd_valid", 32'(load_valid), 32'(ev_l));
                if (ev_l) begin
                    check("load_rd_data", 32'(load_data), 32'(q_load[0].data));
                    void'(q_load.pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ce"},     32'(sram_ce),    32'd0);
        check({tag, "_we"},     32'(sram_we),    32'd0);
        check({tag, "_addr"},   32'(sram_addr),  32'd0);
        check({tag, "_wdata"},  32'(sram_wdata), 32'd0);
        check({tag, "_mvalid"}, 32'(meas_valid), 32'd0);
        check({tag, "_mdata"},  32'(meas_data),  32'd0);
        check({tag, "_lvalid"}, 32'(load_valid), 32'd0);
        check({tag, "_ldata"},  32'(load_data),  32'd0);
        check({tag, "_stall"},  32'(stall_cnt),  32'd0);
        check({tag, "_busy"},   32'(busy),       32'd0);
    endtask

    initial begin
        int nm;
        int lowc;
        int idle;
        bit wr_done;

        rst        = 1'b1;
        meas_req   = 1'b0;
        meas_addr  = '0;
        load_req   = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_wdata = '0;
        stat_clr   = 1'b0;
        ref_mem[18'h00123]  = 16'hBEEF;
        sram_mem[18'h00123] = 16'hBEEF;

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        #1;
        check("reset_meas_ack", 32'(meas_ack), 32'd1);
        check("reset_load_ack", 32'(load_ack), 32'd1);
        rst = 1'b0;

        // Single measurement read
        @(negedge clk);
        meas_req  = 1'b1;
        meas_addr = 18'h00123;
        #1;
        check("t1_ack", 32'(meas_ack), 32'd1);
        @(negedge clk);
        meas_req = 1'b0;
        check("t1_ce", 32'(sram_ce), 32'd1);
        check("t1_we", 32'(sram_we), 32'd0);
        check("t1_addr", 32'(sram_addr), 32'h00123);
        check("t1_busy", 32'(busy), 32'd1);
        repeat (6) @(negedge clk);
        check("t1_data_hold", 32'(meas_data), 32'hBEEF);
        check("t1_load_valid", 32'(load_valid), 32'd0);

        // Back-to-back measurement reads 0x10..0x1F
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("t2_ce", 32'(sram_ce), 32'd1);
                check("t2_addr", 32'(sram_addr), 32'(32'h10 + i - 1));
            end
            meas_req  = 1'b1;
            meas_addr = ADDR_W'(32'h10 + i);
        end
        @(negedge clk);
        check("t2_ce_last", 32'(sram_ce), 32'd1);
        check("t2_addr_last", 32'(sram_addr), 32'h1F);
        meas_req = 1'b0;
        repeat (6) @(negedge clk);
        check("t2_stall", 32'(stall_cnt), 32'd0);
        check("t2_busy_idle", 32'(busy), 32'd0);

        // Loader write behind continuous measurement reads
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr   = 1'b0;
        meas_req   = 1'b1;
        load_req   = 1'b1;
        load_we    = 1'b1;
        load_addr  = 18'h3FFFF;
        load_wdata = 16'h5A5A;
        nm = 0; lowc = 0; idle = 0; wr_done = 1'b0;
        for (int c = 0; c < 40 && !wr_done; c++) begin
            if (nm > 0 && sram_ce == 1'b0) idle++;
            meas_addr = ADDR_W'(32'h20 + nm);
            #1;
            if (meas_ack) nm++;
            else lowc++;
            if (load_ack) wr_done = 1'b1;
            @(negedge clk);
        end
        load_req = 1'b0;
        load_we  = 1'b0;
        check("t3_write_granted", 32'(wr_done), 32'd1);
        check("t3_meas_before_lock", 32'(nm), 32'(WR_STARVE));
        check("t3_ack_low_cycles", 32'(lowc), 32'(RD_LAT + 2));
        check("t3_idle_cycles", 32'(idle), 32'(RD_LAT + 1));
        check("t3_wr_ce", 32'(sram_ce), 32'd1);
        check("t3_wr_we", 32'(sram_we), 32'd1);
        check("t3_wr_addr", 32'(sram_addr), 32'h3FFFF);
        check("t3_wr_wdata", 32'(sram_wdata), 32'h5A5A);
        #1;
        check("t3_meas_resume", 32'(meas_ack), 32'd1);
        check("t3_stall", 32'(stall_cnt), 32'(RD_LAT + 2));
        @(negedge clk);
        meas_addr = 18'h3FFFF;
        @(negedge clk);
        meas_req = 1'b0;
        repeat (6) @(negedge clk);
        check("t3_readback", 32'(meas_data), 32'h5A5A);

        // Interleaved measurement and loader reads
        @(negedge clk);
        meas_req  = 1'b1;
        meas_addr = 18'h00040;
        load_req  = 1'b1;
        load_we   = 1'b0;
        load_addr = 18'h00200;
        #1;
        check("t4_load_blocked", 32'(load_ack), 32'd0);
        @(negedge clk);
        meas_req = 1'b0;
        #1;
        check("t4_load_granted", 32'(load_ack), 32'd1);
        @(negedge clk);
        load_req  = 1'b0;
        meas_req  = 1'b1;
        meas_addr = 18'h00041;
        @(negedge clk);
        meas_req = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_load_data", 32'(load_data), 32'(pat(18'h00200)));
        check("t4_meas_data", 32'(meas_data), 32'(pat(18'h00041)));

        // Reset with two reads in flight
        @(negedge clk);
        meas_req  = 1'b1;
        meas_addr = 18'h00050;
        @(negedge clk);
        meas_addr = 18'h00051;
        @(negedge clk);
        meas_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("t5");
        rst = 1'b0;
        repeat (8) @(negedge clk);
        check("t5_no_meas_valid", 32'(meas_data), 32'd0);

        // Stall counter saturation under a held lock
        force dut.r_starve_cnt = 8'(WR_STARVE);
        meas_req  = 1'b1;
        meas_addr = 18'h00060;
        #1;
        check("t6_locked_ack", 32'(meas_ack), 32'd0);
        repeat (70000) @(negedge clk);
        check("t6_saturate", 32'(stall_cnt), 32'hFFFF);
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check("t6_clear", 32'(stall_cnt), 32'd0);
        @(negedge clk);
        check("t6_recount", 32'(stall_cnt), 32'd1);
        meas_req = 1'b0;
        release dut.r_starve_cnt;
        repeat (4) @(negedge clk);

        check("end_meas_queue", 32'(q_meas.size()), 32'd0);
        check("end_load_queue", 32'(q_load.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/coe_sram_arbiter.md
# coe_sram_arbiter

Shares the single-port external coefficient SRAM (18-bit address, 16-bit data) between two requesters. The distance-calculation lookup path is the high-priority read requester. The coefficient loader (flash/host download, calibration write-back) is the low-priority read/write requester. The block sits between those masters and the SRAM pins. It adds fixed-latency read return with owner tagging, write bus-turnaround protection and a bounded starvation guarantee for the loader.

## Interface
Parameters:
- ADDR_W, 18, SRAM address width
- DATA_W, 16, SRAM data width
- RD_LAT, 2, cycles from o_sram_ce (read) to i_sram_rdata valid; legal 1..4
- WR_STARVE, 8, max consecutive measurement grants while a loader request waits; legal 1..255

Ports:
- i_clk_50m  in  1  sole clock
- i_rst  in  1  synchronous, active-high reset
- i_meas_rd_req  in  1  measurement read request (level, held until accepted)
- i_meas_rd_addr  in  ADDR_W  measurement read address
- o_meas_rd_ack  out  1  combinational ready; transfer when req&&ack at rising edge
- o_meas_rd_valid  out  1  one-cycle pulse, read data returned
- o_meas_rd_data  out  DATA_W  returned data
- i_load_req  in  1  loader request (level)
- i_load_we  in  1  1 = write, 0 = read
- i_load_addr  in  ADDR_W  loader address
- i_load_wdata  in  DATA_W  loader write data
- o_load_ack  out  1  combinational ready for loader
- o_load_rd_valid  out  1  one-cycle pulse, loader read data returned
- o_load_rd_data  out  DATA_W  returned data
- o_sram_ce  out  1  access strobe (registered)
- o_sram_we  out  1  write strobe (registered)
- o_sram_addr  out  ADDR_W  registered address
- o_sram_wdata  out  DATA_W  registered write data
- i_sram_rdata  in  DATA_W  SRAM read data
- i_stat_clr  in  1  clears o_stall_cnt
- o_stall_cnt  out  16  saturating count of cycles with i_meas_rd_req=1 and o_meas_rd_ack=0
- o_busy  out  1  any read in flight or access issued this cycle

## Operation
- At most one access per cycle. Tag pipeline of RD_LAT+1 stages carries {valid, owner} per issued read.
- Grant rules, evaluated every cycle:
  - Measurement: o_meas_rd_ack=1 unless the starvation lock is set.
  - Loader read: o_load_ack=1 when i_meas_rd_req=0 or the lock is set.
  - Loader write: o_load_ack=1 only when the tag pipeline holds no valid read, no read issues this cycle, and the measurement port is not granted. This is the data-bus turnaround rule.
- Starvation counter (8-bit):
  - Increments on each measurement transfer while i_load_req=1.
  - Clears on a loader transfer or when i_load_req=0.
  - Lock sets when the counter equals WR_STARVE. While locked, o_meas_rd_ack=0.
  - For a write under lock, the arbiter idles until the pipeline drains, then grants the loader.
- Lock clears on the loader transfer.
- Write: one cycle with o_sram_ce=o_sram_we=1. The next cycle may issue any access.
- Read return: i_sram_rdata is sampled RD_LAT cycles after o_sram_ce. It is routed to the tagged owner's data output with a one-cycle valid pulse. The data output holds its value until the next return to that owner.
- States: IDLE, READ (reads issuing/in flight), DRAIN (lock or write pending, pipeline emptying), WRITE (one cycle) → IDLE/READ.
- o_stall_cnt saturates at 0xFFFF. i_stat_clr has priority over increment.

## Timing
- Reset values: all strobes, valids, acks-gating state, counters, tag pipeline = 0; data/addr outputs = 0.
- Reset mid-operation discards in-flight reads. No rd_valid is produced for them after reset.
- Transfer at edge k → o_sram_ce/addr/we valid in cycle k+1.
- Read data arrives at the cycle k+1+RD_LAT edge. rd_valid/rd_data are registered and asserted in cycle k+2+RD_LAT.
- Read latency from transfer edge to valid is therefore RD_LAT+2 cycles.
- Measurement-only throughput: 1 read per cycle.
- Write behind reads: the write issues no earlier than RD_LAT+1 cycles after the last read's o_sram_ce.
- Simultaneous requests with lock clear: measurement wins a loader read, and always wins a loader write.

## Test plan
- Single measurement read, RD_LAT=2, addr 0x00123, SRAM returns 0xBEEF → o_sram_ce in cycle k+1, o_meas_rd_valid one pulse in cycle k+4, data 0xBEEF; o_load_rd_valid stays 0.
- Continuous meas reads to 0x10..0x1F, loader idle → 16 consecutive o_sram_ce cycles; 16 valids in address order; o_stall_cnt=0.
- Continuous meas reads plus loader write 0x3FFFF←0x5A5A, WR_STARVE=8 → exactly 8 meas transfers, then meas ack low, RD_LAT+1 idle cycles, one write, meas resumes; o_stall_cnt = RD_LAT+2.
- Interleaved meas read and loader read, with the meas idle gap of one cycle → both returns tagged correctly with no data swap.
- Assert i_rst one cycle after two reads issue → no rd_valid afterward; all outputs 0 in the cycle after reset.
- Hold meas req with forced lock for 70000 cycles → o_stall_cnt saturates at 0xFFFF; i_stat_clr → 0 next cycle.
